// File: rtl/i2c_ctrl_pkg.sv
// Shared definitions for the byte-level I2C master: command codes, FSM state
// encoding and the default lower limit on the prescaler value.
package i2c_ctrl_pkg;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    localparam int unsigned PRESCALER_MIN_DEF = 4;

    // WR_ACK, RD_SYNC, RD_ACK and STOP_P are sub-phases of WRITE, READ and STOP.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START_W  = 4'd1,
        ST_HOLD     = 4'd2,
        ST_RSTART_W = 4'd3,
        ST_WR_BIT   = 4'd4,
        ST_WR_ACK   = 4'd5,
        ST_RD_SYNC  = 4'd6,
        ST_RD_BIT   = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_STOP_W   = 4'd9,
        ST_STOP_P   = 4'd10
    } state_e;

endpackage

// File: rtl/i2c_edge_decode_block.sv
// Decodes the generator edge counter into two single-cycle timing strobes:
// fall_pt_o on the first cycle of SCL low (count == P-1) and mid_hi_o in the
// middle of SCL high (count == P + P/2). Arithmetic is 9 bits wide so large
// prescalers cannot wrap onto a false match.
module i2c_edge_decode_block (
    input  logic [7:0] prescaler_i,
    input  logic [7:0] counter_i,
    output logic       fall_pt_o,
    output logic       mid_hi_o
);

    logic [8:0] fall_cnt;
    logic [8:0] mid_cnt;

    // Compare the counter against the two event points; P=0 yields no events.
    always_comb begin
        fall_cnt  = {1'b0, prescaler_i} - 9'd1;
        mid_cnt   = {1'b0, prescaler_i} + {2'b00, prescaler_i[7:1]};
        fall_pt_o = (prescaler_i != 8'd0) && ({1'b0, counter_i} == fall_cnt);
        mid_hi_o  = (prescaler_i != 8'd0) && ({1'b0, counter_i} == mid_cnt);
    end

endmodule

// File: rtl/i2c_master_byte_ctrl_block.sv
// Byte-level I2C master sequencer. Executes START / WRITE / READ / STOP
// commands against the free-running SCL generator: SDA data changes at the
// FALL_PT strobe, samples and START/STOP edges at the MID_HI strobe. SCL is
// passed to the bus only while the bus is owned (busy_o).
// Command handshake: a command transfers on a cycle where cmd_valid_i and
// cmd_ready_o are both 1; cmd_ready_o depends only on state (IDLE or HOLD).
// Optional macro I2C_MASTER_ARB_LOST_EN adds arbitration-loss detection and
// the sticky arb_lost_o output.
module i2c_master_byte_ctrl_block
    import i2c_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALER_MIN = PRESCALER_MIN_DEF
) (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic [7:0] prescaler_i,
    input  logic       scl_i,
    input  logic [7:0] counter_detect_edge_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] data_i,
    input  logic       ack_send_i,
    output logic [7:0] rd_data_o,
    output logic       ack_rcvd_o,
    output logic       done_o,
    output logic       err_o,
    output logic       busy_o,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       scl_o,
`ifdef I2C_MASTER_ARB_LOST_EN
    output logic       arb_lost_o,
`endif
    output state_e     state_o
);

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic       ack_send_q, ack_send_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ack_rcvd_q, ack_rcvd_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       sda_q, sda_d;
`ifdef I2C_MASTER_ARB_LOST_EN
    logic       arb_lost_q, arb_lost_d;
    logic       arb_chk;
`endif

    logic fall_pt;
    logic mid_hi;
    logic accept;
    logic presc_ok;

    i2c_edge_decode_block u_edge (
        .prescaler_i (prescaler_i),
        .counter_i   (counter_detect_edge_i),
        .fall_pt_o   (fall_pt),
        .mid_hi_o    (mid_hi)
    );

    assign cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign presc_ok    = (32'(prescaler_i) >= PRESCALER_MIN);

    // Next-state and datapath: every bus action waits for its timing strobe.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        ack_send_d = ack_send_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        ack_rcvd_d = ack_rcvd_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        sda_d      = sda_q;
`ifdef I2C_MASTER_ARB_LOST_EN
        arb_lost_d = arb_lost_q;
        arb_chk    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d     = data_i;
                    ack_send_d = ack_send_i;
                    if (!presc_ok || cmd_i != CMD_START) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ST_START_W;
`ifdef I2C_MASTER_ARB_LOST_EN
                        arb_lost_d = 1'b0;
`endif
                    end
                end
            end
            ST_START_W: begin
                if (mid_hi) begin
                    sda_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    data_d     = data_i;
                    ack_send_d = ack_send_i;
                    bit_cnt_d  = 4'd0;
                    if (!presc_ok) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        unique case (cmd_i)
                            CMD_START: begin
                                state_d = ST_RSTART_W;
`ifdef I2C_MASTER_ARB_LOST_EN
                                arb_lost_d = 1'b0;
`endif
                            end
                            CMD_WRITE: state_d = ST_WR_BIT;
                            CMD_READ:  state_d = ST_RD_SYNC;
                            default:   state_d = ST_STOP_W;
                        endcase
                    end
                end
            end
            ST_RSTART_W: begin
                if (fall_pt) begin
                    sda_d   = 1'b1;
                    state_d = ST_START_W;
                end
            end
            ST_WR_BIT: begin
                if (fall_pt) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_d   = 1'b1;
                        state_d = ST_WR_ACK;
                    end else begin
                        sda_d     = data_q[3'd7 - bit_cnt_q[2:0]];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_WR_ACK: begin
                if (mid_hi) begin
                    ack_rcvd_d = sda_i;
                    done_d     = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_RD_SYNC: begin
                if (fall_pt) begin
                    sda_d     = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_RD_BIT;
                end
            end
            ST_RD_BIT: begin
                if (mid_hi && bit_cnt_q != 4'd8) begin
                    shift_d   = {shift_q[6:0], sda_i};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (fall_pt && bit_cnt_q == 4'd8) begin
                    sda_d   = ack_send_q;
                    state_d = ST_RD_ACK;
                end
            end
            ST_RD_ACK: begin
                if (fall_pt) begin
                    sda_d     = 1'b1;
                    rd_data_d = shift_q;
                    done_d    = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_STOP_W: begin
                if (fall_pt) begin
                    sda_d   = 1'b0;
                    state_d = ST_STOP_P;
                end
            end
            ST_STOP_P: begin
                if (mid_hi) begin
                    sda_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef I2C_MASTER_ARB_LOST_EN
        // Released SDA seen low at a sample point: another master owns the bus.
        arb_chk = mid_hi && sda_q && !sda_i &&
                  (state_q == ST_START_W || state_q == ST_WR_BIT || state_q == ST_STOP_W);
        if (arb_chk) begin
            sda_d      = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            err_d      = 1'b1;
            arb_lost_d = 1'b1;
            state_d    = ST_IDLE;
        end
`endif
    end

    // State and datapath registers; reset releases SDA and SCL immediately.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            data_q     <= 8'd0;
            ack_send_q <= 1'b0;
            shift_q    <= 8'd0;
            rd_data_q  <= 8'd0;
            ack_rcvd_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            sda_q      <= 1'b1;
`ifdef I2C_MASTER_ARB_LOST_EN
            arb_lost_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            ack_send_q <= ack_send_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            ack_rcvd_q <= ack_rcvd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            sda_q      <= sda_d;
`ifdef I2C_MASTER_ARB_LOST_EN
            arb_lost_q <= arb_lost_d;
`endif
        end
    end

    assign rd_data_o  = rd_data_q;
    assign ack_rcvd_o = ack_rcvd_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;
    assign sda_o      = sda_q;
    assign scl_o      = busy_q ? scl_i : 1'b1;
    assign state_o    = state_q;
`ifdef I2C_MASTER_ARB_LOST_EN
    assign arb_lost_o = arb_lost_q;
`endif

endmodule

// File: tb/tb_i2c_master_byte_ctrl_block.sv
// Bench for the byte-level I2C master: free-running SCL generator model,
// wired-AND bus with a queued slave, command driver tasks, and a negedge
// monitor that scores completions, SDA bit values at FALL_PT, SDA edge timing
// and SCL gating against expectations pushed by the driver.
module tb_i2c_master_byte_ctrl_block;
    import i2c_ctrl_pkg::*;

    localparam logic [7:0] GEN_P    = 8'd4;
    localparam logic [7:0] TOP_CNT  = 8'd7;
    localparam logic [7:0] FALL_CNT = 8'd3;
    localparam logic [7:0] MID_CNT  = 8'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] prescaler = GEN_P;
    logic [7:0] cnt = TOP_CNT;
    logic       scl_gen;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd = 2'd0;
    logic [7:0] data = 8'd0;
    logic       ack_send = 1'b0;
    logic [7:0] rd_data;
    logic       ack_rcvd, done, err, busy, sda_o, scl_o;
    logic       slave_sda = 1'b1;
    logic       sda_bus;
    state_e     state_dbg;
`ifdef I2C_MASTER_ARB_LOST_EN
    logic       arb_lost;
`endif

    logic [11:0] sb_q[$];
    logic        exp_bit_q[$];
    logic        slave_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        own = 1'b0;
    logic        fall_prev = 1'b0;
    logic        mid_prev = 1'b0;
    logic        sda_prev = 1'b1;

    // Clock and SCL generator model (counts 2P-1 down to 0, SCL high for the top half).
    always #5 clk = ~clk;
    always @(posedge clk) cnt <= (cnt == 8'd0) ? TOP_CNT : cnt - 8'd1;
    assign scl_gen = (cnt >= GEN_P);
    assign sda_bus = sda_o & slave_sda;

    i2c_master_byte_ctrl_block dut (
        .i2c_core_clock_i      (clk),
        .reset_bit_i           (rst_n),
        .prescaler_i           (prescaler),
        .scl_i                 (scl_gen),
        .counter_detect_edge_i (cnt),
        .cmd_valid_i           (cmd_valid),
        .cmd_ready_o           (cmd_ready),
        .cmd_i                 (cmd),
        .data_i                (data),
        .ack_send_i            (ack_send),
        .rd_data_o             (rd_data),
        .ack_rcvd_o            (ack_rcvd),
        .done_o                (done),
        .err_o                 (err),
        .busy_o                (busy),
        .sda_i                 (sda_bus),
        .sda_o                 (sda_o),
        .scl_o                 (scl_o),
`ifdef I2C_MASTER_ARB_LOST_EN
        .arb_lost_o            (arb_lost),
`endif
        .state_o               (state_dbg)
    );

    function automatic logic [11:0] pack(input logic e, input logic b, input logic a,
                                         input logic [7:0] rd, input logic s);
        return {e, b, a, rd, s};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on done_o, bit checks at FALL_PT, SCL gating, SDA edge timing.
    always @(negedge clk) begin
        logic [11:0] e;
        logic        eb;
        if (!rst_n) own = 1'b0;
        chk("scl_gating", {11'd0, scl_o}, {11'd0, own ? scl_gen : 1'b1});
        if (rst_n && sda_o !== sda_prev)
            chk("sda_edge_timing", {11'd0, fall_prev | mid_prev}, 12'd1);
        if (rst_n && fall_prev) begin
            if (exp_bit_q.size() > 0) begin
                eb = exp_bit_q.pop_front();
                chk("sda_bit_at_fall", {11'd0, sda_o}, {11'd0, eb});
            end
            slave_sda = (slave_q.size() > 0) ? slave_q.pop_front() : 1'b1;
        end
        if (err && !done) chk("err_without_done", {11'd0, done}, 12'd1);
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 12'd1, 12'd0);
            end else begin
                e = sb_q.pop_front();
                chk("completion", pack(err, busy, ack_rcvd, rd_data, sda_o), e);
                own = e[10];
            end
        end
        sda_prev  = sda_o;
        fall_prev = (cnt == FALL_CNT);
        mid_prev  = (cnt == MID_CNT);
    end

    // Issue one command; accept edge is aligned to a MID_HI count so it never coincides with FALL_PT.
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
        int n;
        n = 0;
        @(negedge clk);
        while (!(cnt == MID_CNT && cmd_ready === 1'b1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            chk("issue_timeout", 12'd1, 12'd0);
        end else begin
            cmd_valid = 1'b1;
            cmd       = c;
            data      = d;
            ack_send  = a;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic push_write(input logic [7:0] d, input logic slave_ack);
        for (int i = 7; i >= 0; i--) begin
            exp_bit_q.push_back(d[i]);
            slave_q.push_back(1'b1);
        end
        exp_bit_q.push_back(1'b1);
        slave_q.push_back(slave_ack);
    endtask

    task automatic push_read(input logic [7:0] slave_byte, input logic a);
        for (int i = 7; i >= 0; i--) begin
            exp_bit_q.push_back(1'b1);
            slave_q.push_back(slave_byte[i]);
        end
        exp_bit_q.push_back(a);
        exp_bit_q.push_back(1'b1);
        slave_q.push_back(1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || exp_bit_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk("completion_timeout", 12'd1, 12'd0);
            sb_q.delete();
            exp_bit_q.delete();
        end
    endtask

    // Directed sequence.
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sda", {11'd0, sda_o}, 12'd1);
        chk("rst_scl", {11'd0, scl_o}, 12'd1);
        chk("rst_ready", {11'd0, cmd_ready}, 12'd1);
        chk("rst_outputs", pack(err, busy, ack_rcvd, rd_data, done), 12'd0);
        rst_n = 1'b1;

        issue(CMD_START, 8'h00, 1'b0);
        sb_q.push_back(pack(0, 1, 0, 8'h00, 0));
        wait_idle();

        issue(CMD_START, 8'h00, 1'b0);
        exp_bit_q.push_back(1'b1);
        sb_q.push_back(pack(0, 1, 0, 8'h00, 0));
        wait_idle();

        issue(CMD_WRITE, 8'hA5, 1'b0);
        push_write(8'hA5, 1'b0);
        sb_q.push_back(pack(0, 1, 0, 8'h00, 1));
        wait_idle();

        issue(CMD_WRITE, 8'h5A, 1'b0);
        push_write(8'h5A, 1'b1);
        sb_q.push_back(pack(0, 1, 1, 8'h00, 1));
        wait_idle();

        issue(CMD_READ, 8'h00, 1'b1);
        push_read(8'h3C, 1'b1);
        sb_q.push_back(pack(0, 1, 1, 8'h3C, 1));
        wait_idle();

        issue(CMD_READ, 8'h00, 1'b0);
        push_read(8'h81, 1'b0);
        sb_q.push_back(pack(0, 1, 1, 8'h81, 1));
        wait_idle();

        issue(CMD_STOP, 8'h00, 1'b0);
        exp_bit_q.push_back(1'b0);
        sb_q.push_back(pack(0, 0, 1, 8'h81, 1));
        wait_idle();

        issue(CMD_WRITE, 8'h33, 1'b0);
        sb_q.push_back(pack(1, 0, 1, 8'h81, 1));
        wait_idle();

        prescaler = 8'd2;
        issue(CMD_START, 8'h00, 1'b0);
        sb_q.push_back(pack(1, 0, 1, 8'h81, 1));
        wait_idle();
        prescaler = GEN_P;

        issue(CMD_START, 8'h00, 1'b0);
        sb_q.push_back(pack(0, 1, 1, 8'h81, 0));
        wait_idle();
        issue(CMD_WRITE, 8'hA0, 1'b0);
        push_write(8'hA0, 1'b0);
        begin
            int n;
            n = 0;
            while (exp_bit_q.size() > 5 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) chk("bit4_timeout", 12'd1, 12'd0);
        end
        chk("pre_reset_sda_low", {11'd0, sda_o}, 12'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sda", {11'd0, sda_o}, 12'd1);
        chk("mid_rst_scl", {11'd0, scl_o}, 12'd1);
        chk("mid_rst_ready", {11'd0, cmd_ready}, 12'd1);
        chk("mid_rst_outputs", pack(err, busy, ack_rcvd, rd_data, done), 12'd0);
        sb_q.delete();
        exp_bit_q.delete();
        slave_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        issue(CMD_START, 8'h00, 1'b0);
        sb_q.push_back(pack(0, 1, 0, 8'h00, 0));
        wait_idle();
        issue(CMD_STOP, 8'h00, 1'b0);
        exp_bit_q.push_back(1'b0);
        sb_q.push_back(pack(0, 0, 0, 8'h00, 1));
        wait_idle();
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
